// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, bus widths and default timing for the LCD command writer.
package lcd_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam int INST_NUM      = 14;
  localparam int DEF_PWR_CYC   = 1500000;
  localparam int DEF_SETUP_CYC = 10;
  localparam int DEF_E_CYC     = 50;
  localparam int DEF_HOLD_CYC  = 10;
  localparam int DEF_CMD_CYC   = 200000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PWR_WAIT = 3'd1,
    SETUP    = 3'd2,
    E_HIGH   = 3'd3,
    HOLD     = 3'd4,
    CMD_WAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter reload value for a state lasting cyc cycles (never shorter than one).
  function automatic int load_of(input int cyc);
    return (cyc < 1) ? 0 : cyc - 1;
  endfunction

endpackage

// File: rtl/lcd_cmd_writer_if.sv
// lcd_cmd_writer_if: start/status handshake, external ROM port and LCD pins.
interface lcd_cmd_writer_if;
  import lcd_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              lcd_rs;
  logic              lcd_rw;
  logic              lcd_e;
  logic [DATA_W-1:0] lcd_db;

  modport master (
    input  start, rom_data,
    output busy, done, rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport slave (
    output start, rom_data,
    input  busy, done, rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that stops at zero and flags it.
module lcd_timer #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_cmd_writer.sv
// lcd_cmd_writer: plays INST_NUM command bytes from an external ROM onto an HD44780-style bus.
module lcd_cmd_writer
  import lcd_pkg::*;
#(
  parameter int INST_NUM  = lcd_pkg::INST_NUM,
  parameter int PWR_CYC   = DEF_PWR_CYC,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int E_CYC     = DEF_E_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CMD_CYC   = DEF_CMD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_cmd_writer_if.master  bus
);

  localparam int MAX_LD = max_int(max_int(max_int(load_of(PWR_CYC), load_of(SETUP_CYC)),
                                          max_int(load_of(E_CYC), load_of(HOLD_CYC))),
                                  load_of(CMD_CYC));
  localparam int CNT_W  = (MAX_LD < 2) ? 1 : $clog2(MAX_LD + 1);

  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(load_of(PWR_CYC));
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(load_of(SETUP_CYC));
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(load_of(E_CYC));
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(load_of(HOLD_CYC));
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(load_of(CMD_CYC));

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INST_NUM - 1);

  state_t             state;
  state_t             state_nx;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic               db_load;
  logic               start_ok;

  lcd_timer #(
    .WIDTH    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign start_ok = ((state == IDLE) || (state == DONE)) && bus.start;

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx = PWR_WAIT;
          tmr_load = 1'b1;
          tmr_val  = PWR_LD;
        end
      end
      PWR_WAIT: begin
        if (tmr_zero) begin
          state_nx = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_nx = E_HIGH;
          tmr_load = 1'b1;
          tmr_val  = E_LD;
        end
      end
      E_HIGH: begin
        if (tmr_zero) begin
          state_nx = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_nx = CMD_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CMD_LD;
        end
      end
      CMD_WAIT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (bus.rom_addr < LAST_ADDR) begin
            state_nx = SETUP;
            tmr_val  = SETUP_LD;
          end else begin
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The ROM address only settles on SETUP entry, so the bus latches the byte one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.rom_addr <= '0;
      bus.lcd_db   <= '0;
      bus.lcd_e    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      db_load      <= 1'b0;
    end else begin
      state     <= state_nx;
      bus.lcd_e <= (state_nx == E_HIGH);
      bus.busy  <= (state_nx != IDLE) && (state_nx != DONE);
      bus.done  <= (state_nx == DONE);
      db_load   <= (state_nx == SETUP) && (state != SETUP);
      if (db_load) begin
        bus.lcd_db <= bus.rom_data;
      end
      if (start_ok) begin
        bus.rom_addr <= '0;
      end else if ((state == CMD_WAIT) && (state_nx == SETUP)) begin
        bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
      end
    end
  end

  assign bus.lcd_rs = 1'b0;
  assign bus.lcd_rw = 1'b0;

endmodule

// File: doc/lcd_cmd_writer.md
LCD_CMD_WRITER -- requirements
Module: lcd_cmd_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- INST_NUM, 14, commands in ROM.
- PWR_CYC, 1500000, power-on wait cycles.
- SETUP_CYC, 10, RS/DB setup before E rise.
- E_CYC, 50, E high width.
- HOLD_CYC, 10, DB hold after E fall.
- CMD_CYC, 200000, post-command execution wait.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to run the init sequence.
- rom_addr, out, 4, ROM read address.
- rom_data, in, 8, command byte; combinational read of rom_addr.
- lcd_rs, out, 1, register select.
- lcd_rw, out, 1, read/write select.
- lcd_e, out, 1, enable strobe.
- lcd_db, out, 8, data bus.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence complete.
REQ-003 Design SHALL use one clock, clk, with asynchronous active-low reset rst_n; all flops SHALL reset on rst_n low without waiting for clk.

Function
REQ-004 FSM states SHALL be IDLE, PWR_WAIT, SETUP, E_HIGH, HOLD, CMD_WAIT and DONE.
REQ-005 Each timed state (PWR_WAIT, SETUP, E_HIGH, HOLD, CMD_WAIT) SHALL last exactly its parameter count of cycles, with a minimum of 1.
REQ-006 start sampled high in IDLE or DONE SHALL enter PWR_WAIT on the next cycle, set rom_addr=0, busy=1 and done=0.
REQ-007 start SHALL be ignored in every other state.
REQ-008 Transitions SHALL be PWR_WAIT->SETUP, SETUP->E_HIGH, E_HIGH->HOLD, HOLD->CMD_WAIT.
REQ-009 CMD_WAIT SHALL go to SETUP with rom_addr+1 if rom_addr<INST_NUM-1; otherwise it SHALL go to DONE.
REQ-010 On entry to SETUP, lcd_db SHALL register rom_data and hold it unchanged through SETUP, E_HIGH and HOLD.
REQ-011 lcd_e SHALL be 1 only in E_HIGH and SHALL be glitch-free (registered).
REQ-012 lcd_rs SHALL be 0 (instruction register) and lcd_rw SHALL be 0 (write) at all times.
REQ-013 rom_addr SHALL be registered, SHALL change only on the CMD_WAIT->SETUP transition or on start, and SHALL never exceed INST_NUM-1 (no wrap).
REQ-014 In DONE: busy=0, done=1; done SHALL stay high until the next start or reset.
REQ-015 Timing counter width SHALL be sized from the largest parameter; the counter SHALL reload on every state entry and SHALL NOT free-run.
REQ-016 Total cycles from start to done rising SHALL be 1 + PWR_CYC + INST_NUM*(SETUP_CYC+E_CYC+HOLD_CYC+CMD_CYC).

Reset
REQ-017 Reset values SHALL be: state=IDLE, rom_addr=0, lcd_db=0, lcd_e=0, lcd_rs=0, lcd_rw=0, busy=0, done=0, counter=0.
REQ-018 Reset asserted mid-sequence, including during E_HIGH, SHALL drop lcd_e immediately; after release the block SHALL wait in IDLE for start.

Structure
REQ-019 Package lcd_pkg SHALL hold the state enum, INST_NUM and the default timing constants.
REQ-020 One sub-module, lcd_timer (loadable down-counter with a zero flag), SHALL provide all state durations.
REQ-021 The command ROM SHALL stay external, connected through rom_addr and rom_data.

Verification (PWR_CYC=20, SETUP_CYC=2, E_CYC=4, HOLD_CYC=2, CMD_CYC=10; ROM loaded with 0x30+i)
REQ-022 start pulse at cycle 0 -> busy=1 at cycle 1; done=1 at cycle 1+20+14*18=273; exactly 14 lcd_e pulses, each 4 cycles wide.
REQ-023 Capture lcd_db at each lcd_e falling edge -> sequence 0x30..0x3D in order; lcd_rs=lcd_rw=0 throughout.
REQ-024 ROM data changed while lcd_e is high -> lcd_db unchanged until the next SETUP entry.
REQ-025 start re-pulsed during E_HIGH of command 5 -> no effect; the sequence still completes at cycle 273.
REQ-026 rst_n low during the third E_HIGH -> lcd_e=0 and all outputs at reset values within the same cycle; a new start reruns the full 273-cycle sequence.
REQ-027 start in DONE -> done=0 the next cycle, rom_addr=0, and the sequence repeats identically.
